dispatch_station: RTL
=====================

// Module: dispatch_station
// PURPOSE
//  Holds decomposed instructions whose sources are not yet valid, captures late operands from the
//  forwarding bus by register address, and issues the oldest fully-ready entry to its execution unit.
//  Sits between instruction decomposition and the FU, replacing stall-on-error with buffered wakeup.
// PARAMETERS
//  DEPTH   4    number of entries (2..8)
//  IDX_W   2    clog2(DEPTH)
//  INST_W  116  decomposed image: {memdata[115:84],ctrl[83:71],rs2_vt[70:39],s2_valid[38],rs1_vt[37:6],s1_valid[5],rd[4:0]}
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  flush        in   1        synchronous clear of all entries
//  in_valid     in   1        decomposed instruction offered
//  in_ready     out  1        station can accept (= !full)
//  in_inst      in   INST_W   decomposed image
//  in_rs1       in   5        source-1 register address (wakeup match key)
//  in_rs2       in   5        source-2 register address (wakeup match key)
//  fwd_valid    in   1        forwarding bus carries a result this cycle
//  fwd_addr     in   5        destination register of forwarded result
//  fwd_data     in   32       forwarded value
//  issue_valid  out  1        an entry with s1_valid & s2_valid exists
//  issue_ready  in   1        FU accepts
//  issue_inst   out  INST_W   image of oldest ready entry (zero when issue_valid=0)
//  count        out  IDX_W+1  occupied entries
//  full         out  1        count==DEPTH
//  empty        out  1        count==0
// BEHAVIOUR
//  - Reset: all entries invalid; count=0, empty=1, full=0, in_ready=1, issue_valid=0, issue_inst=0.
//  - Storage: collapsing queue, slot 0 oldest; occupied slots always contiguous from slot 0.
//  - Accept: in_valid & in_ready -> write at slot (count - issued_this_cycle); count +1.
//  - Issue: combinational from registered state; selects lowest-index slot with both valid bits.
//    issue_valid & issue_ready -> slot removed, younger slots shift down one; count -1.
//  - Simultaneous accept+issue: count unchanged; new entry lands behind the shifted survivors.
//  - in_ready depends only on full (no combinational path from issue_ready); a full station
//    accepts nothing even in a cycle that issues.
//  - Wakeup: fwd_valid & fwd_addr!=0; every valid slot with s1_valid=0 & rs1==fwd_addr gets
//    rs1_vt<=fwd_data, s1_valid<=1; s2_valid=0 & rs2==fwd_addr gets rs2_vt<=fwd_data,
//    memdata<=fwd_data, s2_valid<=1. Both sources may wake in the same cycle.
//  - Wakeup applies to the entry written this cycle (bypass) and to shifting slots, at the
//    destination slot. Wakeup-to-issue latency 1 cycle; no same-cycle wake-and-issue.
//  - fwd_addr==0 never wakes anything. rd, ctrl and valid source fields are never modified.
//  - flush: all entries invalid next cycle; overrides accept, issue handshake and wakeup in
//    that cycle (issue_valid still reflects pre-flush state; upstream discards).
//  - Equal rs1/rs2 addresses: one forward wakes both.
//  - Reset mid-operation: identical to reset; in-flight images lost, no partial issue.
// TESTING
//  1 Reset then in_inst all sources valid, rd=3 -> next cycle issue_valid=1, issue_inst==in_inst, count=1.
//  2 Entry A (s1 pending rs1=5) then B (ready) -> B issues first; fwd x5=0xDEAD -> A issues next
//    cycle with rs1_vt=0xDEAD, s1_valid=1.
//  3 Store pending rs2=7, fwd x7=0x1234 -> issued image has rs2_vt=memdata=0x1234.
//  4 Fill 4 pending entries -> full=1, in_ready=0; wake slot 1, issue_ready=1 -> slot 1 removed,
//    slots 2,3 shift to 1,2, count=3.
//  5 Accept entry pending on x9 while fwd x9=0x55 same cycle -> stored awake, issues next cycle.
//  6 flush with count=3 and in_valid=1 -> count=0, empty=1, nothing issued afterwards; fwd_addr=0 wakes nothing.

Source files
------------

// File: rtl/dispatch_station.sv
// Dispatch station: collapsing queue of decomposed instructions that wait for late operands
// from the forwarding bus and issue oldest-ready-first to the execution unit.
module dispatch_station #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned IDX_W  = 2,
   parameter int unsigned INST_W = 116
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic              fwd_valid,
   input  logic [4:0]        fwd_addr,
   input  logic [31:0]       fwd_data,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [INST_W-1:0] issue_inst,
   output logic [IDX_W:0]    count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned S1V     = 5;
   localparam int unsigned RS1_LSB = 6;
   localparam int unsigned S2V     = 38;
   localparam int unsigned RS2_LSB = 39;
   localparam int unsigned MEM_LSB = 84;

   logic [INST_W-1:0] img_q [DEPTH];
   logic [4:0]        rs1_q [DEPTH];
   logic [4:0]        rs2_q [DEPTH];
   logic [IDX_W:0]    count_q;

   logic [INST_W-1:0] img_d [DEPTH];
   logic [4:0]        rs1_d [DEPTH];
   logic [4:0]        rs2_d [DEPTH];
   logic [IDX_W:0]    count_d;

   logic              found;
   logic [IDX_W-1:0]  sel;
   logic              fire;
   logic              accept;
   logic              wake_hit;
   int unsigned       cnt_u;
   int unsigned       surv;

   assign cnt_u    = 32'(count_q);
   assign count    = count_q;
   assign full     = (count_q == (IDX_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;

   always_comb begin : select_oldest
      found = 1'b0;
      sel   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!found && i < cnt_u && img_q[i][S1V] && img_q[i][S2V]) begin
            found = 1'b1;
            sel   = IDX_W'(i);
         end
      end
      issue_valid = found;
      issue_inst  = found ? img_q[sel] : '0;
   end

   // Each destination slot pulls from itself or its younger neighbour; the incoming entry lands
   // right behind the survivors, and wakeup is applied after the move so it hits the final slot.
   always_comb begin : next_state
      fire     = found & issue_ready;
      accept   = in_valid & in_ready;
      surv     = cnt_u - (fire ? 32'd1 : 32'd0);
      wake_hit = fwd_valid && (fwd_addr != 5'd0);
      for (int unsigned j = 0; j < DEPTH; j++) begin
         int unsigned src;
         logic        live;
         src      = (fire && j >= 32'(sel)) ? j + 1 : j;
         live     = 1'b0;
         img_d[j] = '0;
         rs1_d[j] = '0;
         rs2_d[j] = '0;
         if (j < surv && src < DEPTH) begin
            live     = 1'b1;
            img_d[j] = img_q[src];
            rs1_d[j] = rs1_q[src];
            rs2_d[j] = rs2_q[src];
         end else if (accept && j == surv) begin
            live     = 1'b1;
            img_d[j] = in_inst;
            rs1_d[j] = in_rs1;
            rs2_d[j] = in_rs2;
         end
         if (live && wake_hit && !img_d[j][S1V] && rs1_d[j] == fwd_addr) begin
            img_d[j][RS1_LSB +: 32] = fwd_data;
            img_d[j][S1V]           = 1'b1;
         end
         if (live && wake_hit && !img_d[j][S2V] && rs2_d[j] == fwd_addr) begin
            img_d[j][RS2_LSB +: 32] = fwd_data;
            img_d[j][MEM_LSB +: 32] = fwd_data;
            img_d[j][S2V]           = 1'b1;
         end
      end
      count_d = count_q - (IDX_W+1)'(fire) + (IDX_W+1)'(accept);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count_q <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            img_q[k] <= '0;
            rs1_q[k] <= '0;
            rs2_q[k] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            img_q[k] <= img_d[k];
            rs1_q[k] <= rs1_d[k];
            rs2_q[k] <= rs2_d[k];
         end
      end
   end

endmodule
